// File: rtl/pkt_reg_pkg.sv
// Shared register map, bit positions and default version for the packet register bank.
package pkt_reg_pkg;

    localparam logic [2:0] ADDR_CTRL     = 3'd0;
    localparam logic [2:0] ADDR_STATUS   = 3'd1;
    localparam logic [2:0] ADDR_IRQ_STAT = 3'd2;
    localparam logic [2:0] ADDR_IRQ_MASK = 3'd3;
    localparam logic [2:0] ADDR_RX_DATA  = 3'd4;
    localparam logic [2:0] ADDR_RX_COUNT = 3'd5;
    localparam logic [2:0] ADDR_SCRATCH  = 3'd6;
    localparam logic [2:0] ADDR_VERSION  = 3'd7;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_IRQ_EN  = 1;
    localparam int CTRL_OVF_CLR = 7;

    localparam int STAT_AVAIL = 0;
    localparam int STAT_FULL  = 1;
    localparam int STAT_OVF   = 2;

    localparam int IRQ_RX  = 0;
    localparam int IRQ_OVF = 1;
    localparam int IRQ_W   = 2;

    localparam logic [7:0] DEFAULT_VERSION = 8'h21;

endpackage

// File: rtl/pkt_rx_fifo.sv
// Small RX byte FIFO: wrap-around pointers plus occupancy count; head entry is read combinationally.
module pkt_rx_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] rd_data,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              push_ok;
    logic              pop_ok;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    // A pop in the same cycle frees the slot the push needs.
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok)
                wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            if (pop_ok)
                rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/pkt_reg_bank.sv
// Control/status register bank for the packet divider/reorder block, with RX byte FIFO and interrupt.
// Bus: wr/rd are single-cycle strobes (wr wins when both are high); rx_valid is a strobe with no backpressure.
module pkt_reg_bank
    import pkt_reg_pkg::*;
#(
    parameter int          ADDR_W   = 3,
    parameter int          DATA_W   = 8,
    parameter int          RX_DEPTH = 4,
    parameter logic [7:0]  VERSION  = DEFAULT_VERSION
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr,
    input  logic              wr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd,
    output logic [DATA_W-1:0] rd_data,
    output logic              int_n,
    input  logic              rx_valid,
    input  logic [DATA_W-1:0] rx_data
);

    localparam int CNT_W = $clog2(RX_DEPTH + 1);

    logic [1:0]        ctrl;
    logic [IRQ_W-1:0]  irq_stat;
    logic [IRQ_W-1:0]  irq_mask;
    logic [IRQ_W-1:0]  irq_stat_nxt;
    logic [IRQ_W-1:0]  irq_clr;
    logic [DATA_W-1:0] scratch;
    logic              ovf;

    logic              mapped;
    logic [2:0]        sel;
    logic              wr_en;
    logic              rd_acc;
    logic              pop;
    logic              push_req;
    logic              rx_push;
    logic              rx_drop;
    logic [DATA_W-1:0] rd_mux;
    logic [2:0]        status;

    logic [DATA_W-1:0] fifo_head;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_full;
    logic              fifo_empty;

    // Only the low eight addresses are decoded; anything above reads zero and ignores writes.
    assign mapped   = ((addr >> 3) == '0);
    assign sel      = addr[2:0];
    assign wr_en    = wr && mapped;
    assign rd_acc   = rd && !wr;
    assign pop      = rd_acc && mapped && (sel == ADDR_RX_DATA) && !fifo_empty;
    assign push_req = rx_valid && ctrl[CTRL_EN];
    assign rx_push  = push_req && (!fifo_full || pop);
    assign rx_drop  = push_req && fifo_full && !pop;
    assign status   = {ovf, fifo_full, !fifo_empty};

    pkt_rx_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (RX_DEPTH)
    ) u_rx_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (rx_push),
        .push_data (rx_data),
        .pop       (pop),
        .rd_data   (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Hardware set beats a simultaneous W1C clear.
    always_comb begin
        irq_clr = '0;
        if (wr_en && (sel == ADDR_IRQ_STAT))
            irq_clr = wr_data[IRQ_W-1:0];
        irq_stat_nxt          = irq_stat & ~irq_clr;
        irq_stat_nxt[IRQ_RX]  = irq_stat_nxt[IRQ_RX]  | rx_push;
        irq_stat_nxt[IRQ_OVF] = irq_stat_nxt[IRQ_OVF] | rx_drop;
    end

    always_comb begin
        rd_mux = '0;
        if (mapped) begin
            case (sel)
                ADDR_CTRL:     rd_mux = DATA_W'(ctrl);
                ADDR_STATUS:   rd_mux = DATA_W'(status);
                ADDR_IRQ_STAT: rd_mux = DATA_W'(irq_stat);
                ADDR_IRQ_MASK: rd_mux = DATA_W'(irq_mask);
                ADDR_RX_DATA:  rd_mux = fifo_empty ? '0 : fifo_head;
                ADDR_RX_COUNT: rd_mux = DATA_W'(fifo_count);
                ADDR_SCRATCH:  rd_mux = scratch;
                ADDR_VERSION:  rd_mux = DATA_W'(VERSION);
                default:       rd_mux = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl     <= '0;
            irq_stat <= '0;
            irq_mask <= '0;
            scratch  <= '0;
            ovf      <= 1'b0;
            rd_data  <= '0;
            int_n    <= 1'b1;
        end else begin
            if (wr_en && (sel == ADDR_CTRL))
                ctrl <= wr_data[1:0];
            if (wr_en && (sel == ADDR_IRQ_MASK))
                irq_mask <= wr_data[IRQ_W-1:0];
            if (wr_en && (sel == ADDR_SCRATCH))
                scratch <= wr_data;
            // Sticky overflow; CTRL bit7 is a write-only clear strobe.
            if (rx_drop)
                ovf <= 1'b1;
            else if (wr_en && (sel == ADDR_CTRL) && wr_data[CTRL_OVF_CLR])
                ovf <= 1'b0;
            irq_stat <= irq_stat_nxt;
            if (rd_acc)
                rd_data <= rd_mux;
            int_n <= ~(ctrl[CTRL_IRQ_EN] && |(irq_stat & irq_mask));
        end
    end

endmodule
